wishbone_rr_arbiter: RTL and testbench

//  NM-master to 1-slave Wishbone B4 classic arbiter with round-robin priority.

---
 rtl/wishbone_rr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter
// Round-robin arbiter that lets NM Wishbone B4 classic masters share one slave port.
// A master keeps the grant for as long as it holds CYC. Each handover passes
// through one IDLE cycle, and a new request never preempts the current owner.
// Build option: define WB_TIMEOUT_EN to add a watchdog. When a slave cycle hangs,
// the watchdog ends it with ERR and then waits in DRAIN until the owner drops CYC.
module wishbone_rr_arbiter #(
  parameter int NM             = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NM*AW-1:0]       mi_addr,
  input  logic [NM*DW-1:0]       mi_dat,
  input  logic [NM-1:0]          mi_we,
  input  logic [NM*(DW/8)-1:0]   mi_sel,
  input  logic [NM-1:0]          mi_stb,
  input  logic [NM-1:0]          mi_cyc,
  output logic [NM*DW-1:0]       mo_dat,
  output logic [NM-1:0]          mo_ack,
  output logic [NM-1:0]          mo_err,
  output logic [AW-1:0]          s_addr,
  output logic [DW-1:0]          s_dat_o,
  output logic                   s_we,
  output logic [DW/8-1:0]        s_sel,
  output logic                   s_stb,
  output logic                   s_cyc,
  input  logic [DW-1:0]          s_dat_i,
  input  logic                   s_ack,
  input  logic                   s_err,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   timeout
);

`ifdef WB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GNT = 2'd1, ST_DRAIN = 2'd2} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GNT = 1'b1} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_grant_id;
  logic [2:0]         r_last;
  logic [2:0]         w_pick;
  logic               w_found;
  logic [3:0]         w_idx;
  logic [7:0]         w_req8;
  logic [7:0]         w_cyc8;
  logic [7:0]         w_stb8;
  logic               w_own_cyc;
  logic               w_own_stb;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_dat;
  logic               w_we;
  logic [DW/8-1:0]    w_sel;
  logic               w_fire;

  // The request vectors are padded to 8 bits, so a 3-bit index can select from them safely for any NM.
  assign w_req8    = 8'(mi_cyc & mi_stb);
  assign w_cyc8    = 8'(mi_cyc);
  assign w_stb8    = 8'(mi_stb);
  assign w_own_cyc = w_cyc8[r_grant_id];
  assign w_own_stb = w_stb8[r_grant_id];
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);

  // Round-robin search: the first requester found when scanning from last+1 and wrapping modulo NM.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NM; k++) begin
      w_idx = {1'b0, r_last} + 4'(k);
      if (w_idx >= 4'(NM)) w_idx = w_idx - 4'(NM);
      if (!w_found && w_req8[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[2:0];
      end
    end
  end

  // Select the owning master's request fields.
  always_comb begin
    w_addr = '0;
    w_dat  = '0;
    w_we   = 1'b0;
    w_sel  = '0;
    for (int i = 0; i < NM; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_addr = mi_addr[i*AW +: AW];
        w_dat  = mi_dat[i*DW +: DW];
        w_we   = mi_we[i];
        w_sel  = mi_sel[i*(DW/8) +: (DW/8)];
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_wdog;

  // The watchdog fires once an unanswered slave cycle has waited the full limit.
  assign w_fire = (r_state == ST_GNT) && (r_wdog == LP_TIMEOUT) && !s_ack && !s_err;

  // Count strobed GNT cycles that get no response. The count is held at zero in IDLE, so every new grant starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == ST_IDLE) begin
      r_wdog <= '0;
    end else if (r_state == ST_GNT) begin
      if (s_ack || s_err) r_wdog <= '0;
      else if (s_stb)     r_wdog <= r_wdog + 16'd1;
    end
  end
`else
  assign w_fire = 1'b0;
`endif

  // State register. An asynchronous reset drops the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Leaving IDLE records the winner, both as the owner and as the rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_id <= '0;
      r_last     <= 3'(NM - 1);
    end else if (r_state == ST_IDLE && w_found) begin
      r_grant_id <= w_pick;
      r_last     <= w_pick;
    end
  end

  // Next-state logic and routing between the owner and the slave.
  always_comb begin
    w_state_nxt = r_state;
    s_cyc       = 1'b0;
    s_stb       = 1'b0;
    s_addr      = '0;
    s_dat_o     = '0;
    s_we        = 1'b0;
    s_sel       = '0;
    mo_ack      = '0;
    mo_err      = '0;
    mo_dat      = '0;
    timeout     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_GNT;
      end
      ST_GNT: begin
        s_cyc   = w_own_cyc;
        s_stb   = w_own_cyc & w_own_stb;
        s_addr  = w_addr;
        s_dat_o = w_dat;
        s_we    = w_we;
        s_sel   = w_sel;
        timeout = w_fire;
        for (int i = 0; i < NM; i++) begin
          if (r_grant_id == 3'(i)) begin
            mo_ack[i]            = s_ack;
            mo_err[i]            = s_err | w_fire;
            mo_dat[i*DW +: DW]   = s_dat_i;
          end
        end
`ifdef WB_TIMEOUT_EN
        if (w_fire)          w_state_nxt = ST_DRAIN;
        else if (!w_own_cyc) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!w_own_cyc) w_state_nxt = ST_IDLE;
      end
`else
        if (!w_own_cyc) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb_wishbone_rr_arbiter
// Testbench for wishbone_rr_arbiter with randomized masters and a randomized slave.
// A cycle-level reference model built from the arbitration rules supplies the expected outputs.
// The watchdog scenario runs only when WB_TIMEOUT_EN is defined.
module tb_wishbone_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NM*AW-1:0] mi_addr = '0;
  logic [NM*DW-1:0] mi_dat = '0;
  logic [NM-1:0]    mi_we = '0;
  logic [NM*SW-1:0] mi_sel = '0;
  logic [NM-1:0]    mi_stb = '0;
  logic [NM-1:0]    mi_cyc = '0;
  logic [NM*DW-1:0] mo_dat;
  logic [NM-1:0]    mo_ack, mo_err;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_dat_o;
  logic             s_we, s_stb, s_cyc;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dat_i = '0;
  logic             s_ack = 1'b0, s_err = 1'b0;
  logic [2:0]       grant_id;
  logic             busy, timeout;

  always #5 clk = ~clk;

  wishbone_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mi_addr(mi_addr), .mi_dat(mi_dat), .mi_we(mi_we), .mi_sel(mi_sel),
    .mi_stb(mi_stb), .mi_cyc(mi_cyc),
    .mo_dat(mo_dat), .mo_ack(mo_ack), .mo_err(mo_err),
    .s_addr(s_addr), .s_dat_o(s_dat_o), .s_we(s_we), .s_sel(s_sel),
    .s_stb(s_stb), .s_cyc(s_cyc),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: 0 idle, 1 granted, 2 draining.
  int m_state, m_owner, m_last, m_cnt, m_age;
  int n_state, n_owner, n_last, n_cnt, n_age;

  // Master and slave stimulus state.
  int beats[NM], cool[NM], sdly[NM];
  logic [AW-1:0] ma[NM];
  logic [DW-1:0] md[NM];
  logic          mw[NM];
  logic [SW-1:0] ms[NM];
  int  sl_ctr, sl_lat, lat_min, lat_max;
  bit  sl_err, sl_hang, err_en, fix_dat_en, auto_refill, rand_spawn;
  logic [DW-1:0] fix_dat;

  // Observations of the DUT.
  int glog[$];
  int gaps[$];
  int dut_acks[NM];
  logic [DW-1:0] last_dat[NM];
  bit prev_busy, to_seen;
  int idle_run, to_age;

  function automatic int rr_pick(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++)
      if (req[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  function automatic int glog_at(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  function automatic int gap_at(input int k);
    return (k < gaps.size()) ? gaps[k] : -1;
  endfunction

  task automatic new_beat();
    sl_ctr = 0;
    sl_lat = $urandom_range(lat_max, lat_min);
    sl_err = err_en && ($urandom_range(15) == 0);
  endtask

  task automatic model_reset();
    m_state = 0; m_owner = 0; m_last = NM - 1; m_cnt = 0; m_age = 0;
    n_state = 0; n_owner = 0; n_last = NM - 1; n_cnt = 0; n_age = 0;
  endtask

  task automatic drive_inputs();
    logic [NM-1:0] c, s;
    bit e_stb;
    for (int i = 0; i < NM; i++) begin
      if (cool[i] > 0) cool[i]--;
      else if (beats[i] == 0 && (auto_refill || (rand_spawn && $urandom_range(3) == 0))) begin
        beats[i] = auto_refill ? 1 : $urandom_range(4, 1);
        sdly[i]  = rand_spawn ? $urandom_range(2, 0) : 0;
        ma[i] = $urandom; md[i] = $urandom;
        mw[i] = 1'($urandom_range(1)); ms[i] = SW'($urandom);
      end
      c[i] = (beats[i] > 0);
      s[i] = c[i] && (sdly[i] == 0);
      mi_addr[i*AW +: AW] = ma[i];
      mi_dat[i*DW +: DW]  = md[i];
      mi_we[i]            = mw[i];
      mi_sel[i*SW +: SW]  = ms[i];
    end
    mi_cyc = c;
    mi_stb = s;
    e_stb   = (m_state == 1) && c[m_owner] && s[m_owner];
    s_ack   = e_stb && !sl_hang && (sl_ctr >= sl_lat) && !sl_err;
    s_err   = e_stb && !sl_hang && (sl_ctr >= sl_lat) && sl_err;
    s_dat_i = fix_dat_en ? fix_dat : DW'($urandom);
  endtask

  task automatic check_and_advance();
    logic [NM-1:0]    e_ack, e_err, req;
    logic [NM*DW-1:0] e_dat;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_wdat;
    logic [SW-1:0]    e_sel;
    logic             e_we, e_cyc, e_stb, fire, gnt;
    int o;
    o = m_owner;
    gnt = (m_state == 1);
`ifdef WB_TIMEOUT_EN
    fire = gnt && (m_cnt == TO) && !s_ack && !s_err;
`else
    fire = 1'b0;
`endif
    e_cyc = gnt && mi_cyc[o];
    e_stb = e_cyc && mi_stb[o];
    e_ack = '0; e_err = '0; e_dat = '0;
    e_addr = '0; e_wdat = '0; e_sel = '0; e_we = 1'b0;
    if (gnt) begin
      e_addr = mi_addr[o*AW +: AW]; e_wdat = mi_dat[o*DW +: DW];
      e_sel  = mi_sel[o*SW +: SW];  e_we   = mi_we[o];
      e_ack[o] = s_ack; e_err[o] = s_err | fire;
      e_dat[o*DW +: DW] = s_dat_i;
    end
    check("busy", busy, m_state != 0);
    check("grant_id", grant_id, o);
    check("s_cyc", s_cyc, e_cyc);
    check("s_stb", s_stb, e_stb);
    check("s_addr", s_addr, e_addr);
    check("s_dat_o", s_dat_o, e_wdat);
    check("s_we", s_we, e_we);
    check("s_sel", s_sel, e_sel);
    check("mo_ack", mo_ack, e_ack);
    check("mo_err", mo_err, e_err);
    check("mo_dat", mo_dat, e_dat);
    check("timeout", timeout, fire);

    if (busy && !prev_busy) begin
      glog.push_back(int'(grant_id));
      gaps.push_back(idle_run);
    end
    if (!busy) idle_run++; else idle_run = 0;
    prev_busy = busy;
    for (int i = 0; i < NM; i++)
      if (mo_ack[i]) begin dut_acks[i]++; last_dat[i] = mo_dat[i*DW +: DW]; end
    if (timeout && !to_seen) begin to_seen = 1'b1; to_age = m_age; end

    for (int i = 0; i < NM; i++) begin
      if (e_err[i] && beats[i] > 0) begin beats[i] = 0; cool[i] = 1; end
      else if (e_ack[i] && beats[i] > 0) begin
        beats[i]--;
        if (beats[i] == 0) cool[i] = 1;
      end
      if (mi_cyc[i] && sdly[i] > 0) sdly[i]--;
    end
    if (e_stb) begin
      if (s_ack || s_err) new_beat();
      else sl_ctr++;
    end

    n_state = m_state; n_owner = m_owner; n_last = m_last; n_cnt = m_cnt; n_age = m_age;
    req = mi_cyc & mi_stb;
    if (m_state == 0) begin
      if (req != '0) begin
        n_owner = rr_pick(req, m_last); n_last = n_owner;
        n_state = 1; n_cnt = 0; n_age = 0;
      end
    end else if (m_state == 1) begin
      n_age = m_age + 1;
      if (s_ack || s_err) n_cnt = 0;
      else if (e_stb)     n_cnt = m_cnt + 1;
      if (fire)              n_state = 2;
      else if (!mi_cyc[o])   n_state = 0;
    end else begin
      if (!mi_cyc[o]) n_state = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    m_state = n_state; m_owner = n_owner; m_last = n_last; m_cnt = n_cnt; m_age = n_age;
    drive_inputs();
    @(negedge clk);
    check_and_advance();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset(input int lmin, input int lmax);
    @(posedge clk); #2;
    rst_n = 1'b0;
    auto_refill = 0; rand_spawn = 0; sl_hang = 0; err_en = 0; fix_dat_en = 0;
    lat_min = lmin; lat_max = lmax;
    for (int i = 0; i < NM; i++) begin
      beats[i] = 0; cool[i] = 0; sdly[i] = 0; dut_acks[i] = 0; last_dat[i] = '0;
    end
    glog.delete(); gaps.delete();
    prev_busy = 0; idle_run = 0; to_seen = 0; to_age = -1;
    model_reset();
    new_beat();
    drive_inputs();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 3'd0);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_s_stb", s_stb, 1'b0);
    check("rst_mo_ack", mo_ack, '0);
    check("rst_mo_err", mo_err, '0);
    check("rst_mo_dat", mo_dat, '0);
    check("rst_timeout", timeout, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int lat_obs;
    bit hit;

    // Single read by master 1, slave answers two cycles after strobe.
    do_reset(2, 2);
    fix_dat_en = 1; fix_dat = 32'hDEADBEEF;
    beats[1] = 1;
    lat_obs = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (s_cyc && lat_obs < 0) lat_obs = k;
    end
    check("req_to_s_cyc", lat_obs, 1);
    check("m1_ack_count", dut_acks[1], 1);
    check("m1_read_data", last_dat[1], 32'hDEADBEEF);
    check("other_acks", dut_acks[0] + dut_acks[2] + dut_acks[3], 0);

    // Masters 0 and 2 together, then both again.
    do_reset(0, 1);
    beats[0] = 1; beats[2] = 1;
    run(16);
    beats[0] = 1; beats[2] = 1;
    run(16);
    check("pair_grant0", glog_at(0), 0);
    check("pair_grant1", glog_at(1), 2);
    check("pair_grant2_wrap", glog_at(2), 0);

    // All masters requesting continuously.
    do_reset(0, 0);
    auto_refill = 1;
    for (int k = 0; k < 80 && glog.size() < 6; k++) cycle();
    auto_refill = 0;
    run(10);
    for (int k = 0; k < 6; k++) check($sformatf("rot_grant%0d", k), glog_at(k), k % NM);
    for (int k = 1; k < 6; k++) check($sformatf("rot_gap%0d", k), gap_at(k), 1);

    // Burst by master 0 while master 3 waits.
    do_reset(0, 2);
    beats[0] = 4; beats[3] = 1;
    run(40);
    check("burst_acks_m0", dut_acks[0], 4);
    check("burst_acks_m3", dut_acks[3], 1);
    check("burst_grant0", glog_at(0), 0);
    check("burst_grant1", glog_at(1), 3);
    check("burst_gap", gap_at(1), 1);

    // Asynchronous reset during master 2's cycle.
    do_reset(6, 6);
    beats[2] = 1;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      cycle();
      hit = (m_state == 1) && (m_owner == 2) && mi_cyc[2];
    end
    check("m2_granted", hit, 1'b1);
    @(posedge clk); #1;
    m_state = n_state; m_owner = n_owner; m_last = n_last; m_cnt = n_cnt; m_age = n_age;
    drive_inputs();
    s_ack = 1'b1;
    #1;
    check("pre_rst_ack", mo_ack, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("async_s_cyc", s_cyc, 1'b0);
    check("async_s_stb", s_stb, 1'b0);
    check("async_mo_ack", mo_ack, '0);
    check("async_busy", busy, 1'b0);
    do_reset(0, 1);
    beats[0] = 1; beats[3] = 1;
    run(16);
    check("post_rst_first", glog_at(0), 0);
    check("post_rst_second", glog_at(1), 3);

`ifdef WB_TIMEOUT_EN
    // A hung slave is ended by the watchdog; the next master proceeds afterwards.
    do_reset(0, 0);
    sl_hang = 1;
    beats[0] = 1; beats[1] = 1;
    for (int k = 0; k < 30 && !to_seen; k++) cycle();
    check("to_fired", to_seen, 1'b1);
    check("to_latency", to_age, TO);
    sl_hang = 0;
    run(20);
    check("to_next_grant", glog_at(1), 1);
    check("to_m1_acks", dut_acks[1], 1);
    check("to_m0_acks", dut_acks[0], 0);
`endif

    // Random traffic against the model.
    do_reset(0, 3);
    rand_spawn = 1; err_en = 1;
    run(1500);
    rand_spawn = 0;
    run(40);
    check("rand_drained", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
